// File: rtl/sd_req_arb.sv
// Round-robin arbiter sharing one host SD slot among NREQ requesters.
// Optional ack-wait timeout is enabled with `define SD_REQ_ARB_TIMEOUT_EN.
module sd_req_arb #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned TMO_BITS = 20
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [32*NREQ-1:0]  req_lba,
    input  logic [NREQ-1:0]     req_rd,
    input  logic [NREQ-1:0]     req_wr,
    output logic [NREQ-1:0]     req_done,
    output logic [NREQ-1:0]     req_err,
    output logic [NREQ-1:0]     req_ack,
    output logic [NREQ-1:0]     req_buff_wr,
    input  logic [8*NREQ-1:0]   req_buff_din,
    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    input  logic                sd_buff_wr,
    output logic [7:0]          sd_buff_din
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StXfer, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic [31:0]     lba_q, lba_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] grant_oh;
    logic            busy;
    logic            timeout;

    // First pending requester after last_served; reverse scan lets the nearest one win.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IdxW-1:0] last);
        logic [IdxW-1:0] pick;
        int unsigned     cand;
        pick = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = (32'(last) + k) % NREQ;
            if (req[cand]) begin
                pick = IdxW'(cand);
            end
        end
        return pick;
    endfunction

    assign pend       = req_rd | req_wr;
    assign pick_valid = |pend;
    assign pick_idx   = rr_pick(pend, last_q);

    assign busy     = (state_q != StIdle);
    assign grant_oh = busy ? (NREQ'(1) << grant_q) : '0;

    assign req_ack     = grant_oh & {NREQ{sd_ack}};
    assign req_buff_wr = grant_oh & {NREQ{sd_buff_wr}};
    assign req_done    = (state_q == StDone) ? grant_oh : '0;
    assign sd_buff_din = busy ? req_buff_din[8*grant_q +: 8] : 8'h00;

    assign sd_lba = lba_q;
    assign sd_rd  = rd_q;
    assign sd_wr  = wr_q;

`ifdef SD_REQ_ARB_TIMEOUT_EN
    // Counter value one short of all-ones: the edge that would reach 2^TMO_BITS-1 aborts.
    localparam logic [TMO_BITS-1:0] TmoLast = ~TMO_BITS'(1);

    logic [TMO_BITS-1:0] tmo_q;
    logic [NREQ-1:0]     err_q;

    assign timeout = (state_q == StIssue) && !sd_ack && (tmo_q == TmoLast);
    assign req_err = err_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            err_q <= '0;
        end else begin
            tmo_q <= (state_q == StIssue) ? tmo_q + 1'b1 : '0;
            err_q <= timeout ? grant_oh : '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign req_err = '0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StIssue;
                    grant_d = pick_idx;
                    lba_d   = req_lba[32*pick_idx +: 32];
                    // Read wins when both strobes are set.
                    rd_d    = req_rd[pick_idx];
                    wr_d    = !req_rd[pick_idx];
                end
            end
            StIssue: begin
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StXfer;
                end else if (timeout) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            StXfer: begin
                if (!sd_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                last_d  = grant_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IdxW'(NREQ - 1);
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: doc/sd_req_arb.md
SD_REQ_ARB -- requirements
Module: sd_req_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing one host SD slot (range 1..4).
REQ-002 SHALL have parameter TMO_BITS, default 20, width of the ack-wait timeout counter.
REQ-003 SHALL have port clk_sys, input, 1 bit, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port req_lba, input, 32*NREQ bits, sector LBA of requester i at bits [32i+31:32i].
REQ-006 SHALL have port req_rd, input, NREQ bits, level read request per requester.
REQ-007 SHALL have port req_wr, input, NREQ bits, level write request per requester.
REQ-008 SHALL have port req_done, output, NREQ bits, one-cycle completion pulse per requester.
REQ-009 SHALL have port req_err, output, NREQ bits, one-cycle timeout-abort pulse per requester.
REQ-010 SHALL have port req_ack, output, NREQ bits, sd_ack routed to the granted requester only.
REQ-011 SHALL have port req_buff_wr, output, NREQ bits, sd_buff_wr routed to the granted requester only.
REQ-012 SHALL have port req_buff_din, input, 8*NREQ bits, write data per requester.
REQ-013 SHALL have port sd_lba, output, 32 bits, LBA to host interface.
REQ-014 SHALL have ports sd_rd and sd_wr, outputs, 1 bit each, host slot request strobes.
REQ-015 SHALL have ports sd_ack and sd_buff_wr, inputs, 1 bit each, from host interface.
REQ-016 SHALL have port sd_buff_din, output, 8 bits, req_buff_din of granted requester, combinational mux; 0 when idle.

Function
REQ-017 SHALL implement states IDLE, ISSUE, XFER, DONE.
REQ-018 In IDLE, with any req_rd|req_wr set, SHALL grant by round-robin starting at (last_served+1) mod NREQ and enter ISSUE next edge.
REQ-019 On grant SHALL register sd_lba from the granted requester; sd_rd or sd_wr rises in the same edge (1-cycle latency from request).
REQ-020 If a requester asserts both req_rd and req_wr, SHALL treat it as a read.
REQ-021 In ISSUE, on sd_ack=1, SHALL drop sd_rd/sd_wr and enter XFER.
REQ-022 In XFER, on sd_ack=0, SHALL enter DONE.
REQ-023 In DONE, SHALL pulse req_done[grant] one cycle, record last_served, release grant, return to IDLE.
REQ-024 Requester SHALL hold its request until req_done/req_err; a request still held after DONE is re-arbitrated as a new transaction.
REQ-025 sd_lba SHALL remain stable from grant until return to IDLE.
REQ-026 req_ack and req_buff_wr SHALL be zero for non-granted requesters at all times.
REQ-027 A request deasserted before its grant SHALL be dropped silently; deassertion after grant SHALL not abort.
REQ-028 With NREQ=1, SHALL behave as a pass-through sequencer with identical timing.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, sd_rd=0, sd_wr=0, sd_lba=0, req_done=0, req_err=0, grant none, last_served=NREQ-1 (requester 0 served first).
REQ-030 Reset mid-transfer SHALL abandon the transaction without req_done or req_err.

Configuration
REQ-031 Macro SD_REQ_ARB_TIMEOUT_EN defined: counter clears on entering ISSUE, counts in ISSUE; on reaching 2^TMO_BITS-1 without sd_ack, SHALL drop sd_rd/sd_wr, pulse req_err[grant], update last_served, return to IDLE.
REQ-032 Macro SD_REQ_ARB_TIMEOUT_EN undefined: no counter; ISSUE waits indefinitely; req_err tied 0.

Verification
REQ-033 NREQ=2, req_rd[0]=1, req_lba0=0x00001234 -> next cycle sd_rd=1, sd_lba=0x00001234; sd_ack 1 for 10 cycles then 0 -> req_done[0] one pulse, no req_done[1].
REQ-034 req_wr[0] and req_wr[1] raised same cycle after reset -> requester 0 served first, requester 1 second; held again -> requester 0 third (round-robin).
REQ-035 During requester 1 grant, sd_buff_wr pulses 512 times -> req_buff_wr[1] 512 pulses, req_buff_wr[0] zero; sd_buff_din equals req_buff_din[15:8].
REQ-036 req_rd[0]=req_wr[0]=1 -> sd_rd=1, sd_wr=0.
REQ-037 reset_n low while in XFER -> sd_rd=sd_wr=0 same cycle, no req_done; after release, pending req_rd[1] granted normally.
REQ-038 With SD_REQ_ARB_TIMEOUT_EN, TMO_BITS=4, sd_ack held 0 -> req_err[0] pulse 15 cycles after ISSUE entry, sd_rd=0, state IDLE.
